instr_decode_unit: RTL
======================

Name: instr_decode_unit

Overview:
- Front-end stage directly upstream of the multicycle control FSM.
- Latches the fetched instruction word on IW and holds the architectural condition flags (Z,N,C,V), updated on FU.
- Produces Op, LMC and Perform for the FSM, plus the operand fields for the datapath.
- Perform is evaluated from the latched condition field against the current flags.

Parameters:
- IWIDTH, 16, instruction word width; field positions below are fixed for 16.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- InstrIn  in  IWIDTH  instruction word from memory.
- IW  in  1  instruction write strobe from the FSM (fetch state).
- FU  in  1  flag update strobe from the FSM (compare/ALU state).
- ALUFlags  in  4  {Z,N,C,V} produced by the ALU this cycle.
- FW  in  1  explicit flag write (flag restore).
- FlagsIn  in  4  {Z,N,C,V} value for FW.
- Decode  in  1  high while the FSM is in its decode state.
- Op  out  4  IR[15:12].
- LMC  out  1  IR[8], memory-operand bit.
- Perform  out  1  condition-pass result.
- Cond  out  3  IR[11:9].
- Imm  out  8  IR[7:0].
- Flags  out  4  current {Z,N,C,V}.
- IRValid  out  1  an instruction has been latched since reset.

Behaviour:
- Reset (RESET=0, asynchronous): IR=0, Flags=0, IRValid=0, and counters=0 if present. Op, LMC, Cond and Imm therefore read 0. Perform=0.
- IR load: on a rising edge with IW=1, IR<=InstrIn and IRValid<=1. Decoded outputs change the cycle after IW, which is the first decode cycle. IR holds otherwise.
- Decoded outputs are pure combinational slices of IR. No extra latency.
- Flags: on a rising edge with FU=1, Flags<=ALUFlags. Else if FW=1, Flags<=FlagsIn. FU has priority when both are asserted. Flags hold otherwise.
- IW and FU in the same cycle: both registers update. The new IR is evaluated against the new flags in the next cycle.
- Perform is combinational from IR.Cond, Flags and IRValid. It is forced to 0 when IRValid=0. Condition encoding:
  - 000 always
  - 001 EQ (Z)
  - 010 NE (!Z)
  - 011 LT (N^V)
  - 100 GE (!(N^V))
  - 101 CS (C)
  - 110 CC (!C)
  - 111 never
- A flag update during an instruction's execute state does not affect that instruction's already-consumed Perform. The FSM samples Perform only in decode.
- Reset mid-instruction: everything clears immediately. After RESET rises, Perform stays 0 until the first IW.
- IW while RESET=0 is ignored.

Optional Feature:
- Macro: INSTR_DECODE_PERF_EN.
- When defined, adds outputs RetiredCnt and SkippedCnt (each CNT_W, out).
  - RetiredCnt increments on each IW edge when IRValid=1, i.e. the previous instruction has completed.
  - SkippedCnt increments on each edge where Decode=1 and Perform=0.
  - Both wrap from all-ones to 0 and reset to 0.
- When not defined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset then IW with InstrIn=16'h1234 → next cycle Op=1, Cond=1, LMC=0, Imm=8'h34, IRValid=1. Flags=0 so EQ fails: Perform=0.
- FU with ALUFlags=4'b1000 (Z=1), IR cond=001 → Perform=1 next cycle. Change IR to cond=010 → Perform=0.
- FU=1 with ALUFlags=4'b0100 and FW=1 with FlagsIn=4'b0011 in the same cycle → Flags=4'b0100 (FU wins).
- Flags N=1,V=0: cond 011 → Perform=1; cond 100 → Perform=0; cond 111 → 0; cond 000 → 1.
- Drive RESET low mid-cycle after loading 16'hF000 → Op=0, Perform=0 and Flags=0 immediately, without waiting for CLK. First IW after release sets IRValid.
- With INSTR_DECODE_PERF_EN defined and CNT_W=4:
  - 17 IW pulses → RetiredCnt=0 (16 counted, then wrap).
  - Decode=1 with cond=111 for 3 cycles → SkippedCnt=3.

Source files
------------

// File: rtl/instr_decode_unit.sv
// ---------------------------------------------------------------------------
// instr_decode_unit
//
// Front-end stage that sits directly ahead of the multicycle control FSM.
// It holds the fetched instruction word (IR) and the architectural condition
// flags {Z,N,C,V}. It presents the decoded instruction fields to the FSM and
// the datapath, together with the condition-pass result (Perform) that the
// FSM samples in its decode state.
//
// Optional feature (macro INSTR_DECODE_PERF_EN):
//   Adds the RetiredCnt and SkippedCnt performance counters. When the macro
//   is undefined, those ports and counters are absent and the rest of the
//   behaviour is unchanged.
//
// Parameters:
//   IWIDTH   instruction word width; field positions assume 16
//   CNT_W    performance counter width (optional feature only)
//
// Ports:
//   CLK         in   clock, rising-edge active
//   RESET       in   asynchronous active-low reset
//   InstrIn     in   instruction word from memory
//   IW          in   instruction write strobe (fetch state)
//   FU          in   flag update strobe from the ALU state
//   ALUFlags    in   {Z,N,C,V} produced by the ALU
//   FW          in   explicit flag write (flag restore)
//   FlagsIn     in   {Z,N,C,V} value written on FW
//   Decode      in   high while the FSM is in decode
//   Op          out  IR[15:12]
//   LMC         out  IR[8], memory-operand bit
//   Perform     out  condition-pass result
//   Cond        out  IR[11:9]
//   Imm         out  IR[7:0]
//   Flags       out  current {Z,N,C,V}
//   IRValid     out  an instruction has been latched since reset
//   RetiredCnt  out  instructions completed (INSTR_DECODE_PERF_EN only)
//   SkippedCnt  out  decode cycles with failed condition (INSTR_DECODE_PERF_EN only)
// ---------------------------------------------------------------------------
module instr_decode_unit #(
  parameter int IWIDTH = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [IWIDTH-1:0] InstrIn,
  input  logic              IW,
  input  logic              FU,
  input  logic [3:0]        ALUFlags,
  input  logic              FW,
  input  logic [3:0]        FlagsIn,
  input  logic              Decode,
  output logic [3:0]        Op,
  output logic              LMC,
  output logic              Perform,
  output logic [2:0]        Cond,
  output logic [7:0]        Imm,
  output logic [3:0]        Flags,
  output logic              IRValid
`ifdef INSTR_DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0]  RetiredCnt,
  output logic [CNT_W-1:0]  SkippedCnt
`endif
);

  // Field slices below are hard-wired for a 16-bit instruction word.
  if (IWIDTH != 16) begin : g_bad_iwidth
    $error("instr_decode_unit: IWIDTH must be 16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("instr_decode_unit: CNT_W must be at least 1");
  end

  // Condition codes carried in IR[11:9].
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_CS = 3'b101;
  localparam logic [2:0] COND_CC = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // Evaluates a condition code against a {Z,N,C,V} flag vector.
  function automatic logic cond_pass(input logic [2:0] cc, input logic [3:0] zncv);
    logic z, n, c, v;
    logic pass;
    z = zncv[3];
    n = zncv[2];
    c = zncv[1];
    v = zncv[0];
    unique case (cc)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_LT: pass = n ^ v;
      COND_GE: pass = ~(n ^ v);
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  logic [IWIDTH-1:0] ir_p0;
  logic [3:0]        flags_p0;
  logic              vld_p0;
  logic              perform_p0;

  // ---- Stage p0: instruction and flag registers ----
  // The whole state is architectural, so everything clears on reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ir_p0  <= '0;
      vld_p0 <= 1'b0;
    end else if (IW) begin
      ir_p0  <= InstrIn;
      vld_p0 <= 1'b1;
    end
  end

  // FU outranks FW: an ALU result in the same cycle as a restore wins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flags_p0 <= '0;
    end else if (FU) begin
      flags_p0 <= ALUFlags;
    end else if (FW) begin
      flags_p0 <= FlagsIn;
    end
  end

  // ---- Stage p0 outputs: combinational decode of the held IR ----
  // Perform is gated by vld_p0 so the reset image of IR (cond=000, "always")
  // never reports a pass before a real instruction has been fetched.
  always_comb begin
    perform_p0 = vld_p0 & cond_pass(ir_p0[11:9], flags_p0);
  end

  assign Op      = ir_p0[15:12];
  assign Cond    = ir_p0[11:9];
  assign LMC     = ir_p0[8];
  assign Imm     = ir_p0[7:0];
  assign Flags   = flags_p0;
  assign IRValid = vld_p0;
  assign Perform = perform_p0;

`ifdef INSTR_DECODE_PERF_EN
  logic [CNT_W-1:0] retired_p1;
  logic [CNT_W-1:0] skipped_p1;

  // ---- Stage p1: performance counters ----
  // A fetch while an instruction is already held means that instruction has
  // completed. Both counters wrap naturally at all-ones.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      retired_p1 <= '0;
      skipped_p1 <= '0;
    end else begin
      if (IW && vld_p0) begin
        retired_p1 <= retired_p1 + 1'b1;
      end
      if (Decode && !perform_p0) begin
        skipped_p1 <= skipped_p1 + 1'b1;
      end
    end
  end

  assign RetiredCnt = retired_p1;
  assign SkippedCnt = skipped_p1;
`else
  // Decode only feeds the performance counters.
  logic unused_decode;
  assign unused_decode = Decode;
`endif

endmodule
